main_memory_burst: RTL and testbench
====================================

MAIN_MEMORY_BURST -- requirements
Module: main_memory_burst

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter DATA_W, default 8, storage word width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 8; storage depth is 2^DEPTH_LOG2 words.
REQ-004 SHALL have parameter LINE_WORDS, default 4, burst length; power of two, 2..2^DEPTH_LOG2.
REQ-005 SHALL have parameter LATENCY, default 3, cycles from request accept to first response beat; legal range >=1.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 req_valid  in  1  request present.
REQ-010 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-011 req_write  in  1  1 = write, 0 = read.
REQ-012 req_burst  in  1  1 = line read of LINE_WORDS beats; ignored when req_write=1.
REQ-013 req_addr  in  ADDR_W  word address.
REQ-014 req_wdata  in  DATA_W  write data.
REQ-015 resp_valid  out  1  response beat present.
REQ-016 resp_ready  in  1  downstream accepts beat.
REQ-017 resp_rdata  out  DATA_W  read data; 0 on write acknowledge.
REQ-018 resp_last  out  1  final beat of a response.
REQ-019 init_done  out  1  storage initialisation complete.

Function
REQ-020 SHALL index storage with req_addr[DEPTH_LOG2-1:0]; upper address bits ignored (aliasing).
REQ-021 SHALL implement states INIT, IDLE, WAIT, RESP.
REQ-022 INIT: counter sweeps index 0..2^DEPTH_LOG2-1, one word per cycle, writing word[i] = i truncated/zero-extended to DATA_W; after last word -> IDLE, init_done=1 and held until reset.
REQ-023 req_ready SHALL be 1 only in IDLE; requests in INIT/WAIT/RESP are stalled, not dropped.
REQ-024 Accept (IDLE, req_valid & req_ready) SHALL capture write flag, burst flag, index, wdata; go to WAIT with latency counter loaded.
REQ-025 Writes SHALL update storage on the accept edge.
REQ-026 WAIT SHALL last exactly LATENCY cycles after accept; resp_valid first high in the LATENCY-th cycle after the accept edge, then state RESP.
REQ-027 Single read/write: one beat, resp_last=1; read returns word[index]; write returns resp_rdata=0.
REQ-028 Burst read: LINE_WORDS beats, critical word first, wrapping within the aligned line: beat n returns word[{index upper bits, (index low log2(LINE_WORDS) bits + n) mod LINE_WORDS}]; resp_last=1 only on beat LINE_WORDS-1.
REQ-029 Beat advances only on resp_valid & resp_ready; while resp_valid & !resp_ready, resp_rdata and resp_last SHALL hold stable.
REQ-030 Consecutive beats SHALL issue back-to-back (no gap) while resp_ready=1.
REQ-031 After last beat handshake -> IDLE; req_ready=1 the following cycle (no same-cycle turnaround).
REQ-032 resp_valid SHALL never be high outside RESP.

Reset
REQ-033 rst_n low SHALL immediately force: state INIT, init counter 0, req_ready=0, resp_valid=0, resp_last=0, resp_rdata=0, init_done=0, latency/beat counters 0.
REQ-034 Reset mid-operation SHALL abort any response without a further beat; INIT reruns after release and restores the full init pattern, overwriting prior writes.
REQ-035 Storage array itself needs no asynchronous reset; INIT sweep defines contents.

Verification
REQ-036 Release reset -> init_done rises after 256 cycles; read 0x0000_00A5 -> one beat 0xA5, resp_last=1, resp_valid in the 3rd cycle after accept.
REQ-037 Write 0x3C @0x12 -> ack beat rdata 0x00 last=1; then read 0x12 -> 0x3C.
REQ-038 Burst read @0x46 -> beats 0x46, 0x47, 0x44, 0x45, resp_last only on 4th, no gaps with resp_ready=1.
REQ-039 Burst @0x40, resp_ready low 2 cycles on beat 1 -> 0x41 held stable, then 0x42, 0x43 follow; no beat lost or duplicated.
REQ-040 Read 0xFFFF_FF10 -> 0x10; req_write=1 with req_burst=1 @0x20 data 0x77 -> single ack beat, read 0x20 -> 0x77.
REQ-041 Write 0x99 @0x05, start burst, assert rst_n low mid-burst -> resp_valid 0 immediately; after re-init read 0x05 -> 0x05.

Source files
------------

// File: rtl/main_memory_burst_if.sv
// Request/response bus between a requester and the burst-capable main memory.
`timescale 1ns/1ps
interface main_memory_burst_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_burst;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_last;

  modport master (
    output req_valid, req_write, req_burst, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_last
  );

  modport slave (
    input  req_valid, req_write, req_burst, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_last
  );
endinterface

// File: rtl/main_memory_burst.sv
// Main memory model: self-initialising storage, fixed request latency,
// single-word reads/writes and critical-word-first wrapping burst reads.
`timescale 1ns/1ps
module main_memory_burst #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  main_memory_burst_if.slave  bus,
  output logic                init_done
);
  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned LW_LOG2  = $clog2(LINE_WORDS);
  localparam int unsigned LAT_W    = $clog2(LATENCY + 1);
  localparam int unsigned LAT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [DEPTH_LOG2-1:0] LINE_MASK = DEPTH_LOG2'(LINE_WORDS - 1);
  localparam logic [LW_LOG2-1:0]    LAST_BEAT = LW_LOG2'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 state;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  init_cnt;
  logic [DEPTH_LOG2-1:0]  idx;
  logic [DEPTH_LOG2-1:0]  req_idx;
  logic [DEPTH_LOG2-1:0]  next_idx;
  logic [LAT_W-1:0]       lat_cnt;
  logic [LW_LOG2-1:0]     beat;
  logic [LW_LOG2-1:0]     beat_nxt;
  logic                   is_write;
  logic                   is_burst;
  logic                   accept;
  logic                   mem_we;
  logic [DEPTH_LOG2-1:0]  mem_wa;
  logic [DATA_W-1:0]      mem_wd;

  assign req_idx = bus.req_addr[DEPTH_LOG2-1:0];
  assign accept  = (state == S_IDLE) && bus.req_valid && bus.req_ready;

  // Next beat stays inside the aligned line: keep upper bits, wrap the offset.
  always_comb begin
    beat_nxt = beat + LW_LOG2'(1);
    next_idx = (idx & ~LINE_MASK) | ((idx + DEPTH_LOG2'(beat_nxt)) & LINE_MASK);
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (state == S_INIT) begin
      mem_we = 1'b1;
      mem_wa = init_cnt;
      mem_wd = DATA_W'(init_cnt);
    end else if (accept && bus.req_write) begin
      mem_we = 1'b1;
      mem_wa = req_idx;
      mem_wd = bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_INIT;
      init_cnt       <= '0;
      init_done      <= 1'b0;
      idx            <= '0;
      lat_cnt        <= '0;
      beat           <= '0;
      is_write       <= 1'b0;
      is_burst       <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_last  <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + DEPTH_LOG2'(1);
          if (init_cnt == '1) begin
            state         <= S_IDLE;
            init_done     <= 1'b1;
            bus.req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            bus.req_ready <= 1'b0;
            is_write      <= bus.req_write;
            is_burst      <= bus.req_burst & ~bus.req_write;
            idx           <= req_idx;
            beat          <= '0;
            // A one-cycle latency leaves no room for WAIT: present beat 0 directly.
            if (LATENCY == 1) begin
              state          <= S_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= bus.req_write ? '0 : mem[req_idx];
              bus.resp_last  <= bus.req_write | ~bus.req_burst;
            end else begin
              state   <= S_WAIT;
              lat_cnt <= LAT_W'(LAT_LOAD);
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            state          <= S_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= is_write ? '0 : mem[idx];
            bus.resp_last  <= ~is_burst;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            if (bus.resp_last) begin
              state          <= S_IDLE;
              bus.resp_valid <= 1'b0;
              bus.resp_last  <= 1'b0;
              bus.resp_rdata <= '0;
              bus.req_ready  <= 1'b1;
              beat           <= '0;
            end else begin
              beat           <= beat_nxt;
              bus.resp_rdata <= mem[next_idx];
              bus.resp_last  <= (beat_nxt == LAST_BEAT);
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_main_memory_burst.sv
// Directed bench for main_memory_burst: init sweep, latency, single/burst
// reads, writes, back-pressure, address aliasing and mid-burst reset.
`timescale 1ns/1ps
module tb_main_memory_burst;
  logic clk;
  logic rst_n;
  logic init_done;
  int   checks;
  int   errors;

  main_memory_burst_if #(.ADDR_W(32), .DATA_W(8)) bus ();

  main_memory_burst #(
    .ADDR_W(32), .DATA_W(8), .DEPTH_LOG2(8), .LINE_WORDS(4), .LATENCY(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and verify the fixed three-cycle latency to beat 0.
  task automatic send(input string tag, input logic w, input logic b,
                      input logic [31:0] a, input logic [7:0] d);
    int unsigned n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_burst = b;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_burst = 1'b0;
    check({tag, "_lat1_valid"}, bus.resp_valid, 0);
    check({tag, "_lat1_ready"}, bus.req_ready, 0);
    tick();
    check({tag, "_lat2_valid"}, bus.resp_valid, 0);
    tick();
    check({tag, "_lat3_valid"}, bus.resp_valid, 1);
  endtask

  // Check the presented beat, then let the handshake edge pass.
  task automatic beat(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, bus.resp_valid, 1);
    check({tag, "_data"}, bus.resp_rdata, d);
    check({tag, "_last"}, bus.resp_last, l);
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_valid"}, bus.resp_valid, 0);
    check({tag, "_idle_ready"}, bus.req_ready, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_burst  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    #12;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_last", bus.resp_last, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_init_done", init_done, 0);

    tick();
    rst_n = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    check("init_255", init_done, 0);
    check("init_255_ready", bus.req_ready, 0);
    tick();
    check("init_256", init_done, 1);
    check("init_256_ready", bus.req_ready, 1);

    send("rd_a5", 1'b0, 1'b0, 32'h0000_00A5, 8'h00);
    beat("rd_a5_b0", 8'hA5, 1'b1);
    check_idle("rd_a5");

    send("wr_12", 1'b1, 1'b0, 32'h0000_0012, 8'h3C);
    beat("wr_12_ack", 8'h00, 1'b1);
    send("rd_12", 1'b0, 1'b0, 32'h0000_0012, 8'h00);
    beat("rd_12_b0", 8'h3C, 1'b1);

    send("bu_46", 1'b0, 1'b1, 32'h0000_0046, 8'h00);
    beat("bu_46_b0", 8'h46, 1'b0);
    beat("bu_46_b1", 8'h47, 1'b0);
    beat("bu_46_b2", 8'h44, 1'b0);
    beat("bu_46_b3", 8'h45, 1'b1);
    check_idle("bu_46");

    send("bu_40", 1'b0, 1'b1, 32'h0000_0040, 8'h00);
    beat("bu_40_b0", 8'h40, 1'b0);
    bus.resp_ready = 1'b0;
    beat("bu_40_st1", 8'h41, 1'b0);
    beat("bu_40_st2", 8'h41, 1'b0);
    bus.resp_ready = 1'b1;
    beat("bu_40_b1", 8'h41, 1'b0);
    beat("bu_40_b2", 8'h42, 1'b0);
    beat("bu_40_b3", 8'h43, 1'b1);
    check_idle("bu_40");

    send("rd_alias", 1'b0, 1'b0, 32'hFFFF_FF10, 8'h00);
    beat("rd_alias_b0", 8'h10, 1'b1);
    send("wr_burst_20", 1'b1, 1'b1, 32'h0000_0020, 8'h77);
    beat("wr_burst_20_ack", 8'h00, 1'b1);
    check_idle("wr_burst_20");
    send("rd_20", 1'b0, 1'b0, 32'h0000_0020, 8'h00);
    beat("rd_20_b0", 8'h77, 1'b1);

    send("wr_05", 1'b1, 1'b0, 32'h0000_0005, 8'h99);
    beat("wr_05_ack", 8'h00, 1'b1);
    send("rd_05", 1'b0, 1'b0, 32'h0000_0005, 8'h00);
    beat("rd_05_b0", 8'h99, 1'b1);
    send("bu_04", 1'b0, 1'b1, 32'h0000_0004, 8'h00);
    beat("bu_04_b0", 8'h04, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.resp_valid, 0);
    check("mid_rst_last", bus.resp_last, 0);
    check("mid_rst_ready", bus.req_ready, 0);
    check("mid_rst_init_done", init_done, 0);
    tick();
    rst_n = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    check("reinit_done", init_done, 1);
    send("rd_05_after", 1'b0, 1'b0, 32'h0000_0005, 8'h00);
    beat("rd_05_after_b0", 8'h05, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
